float_unpack_arbiter: RTL and testbench

Round-robin arbiter that shares one float-unpack stage among `NUM_REQ` operand streams of the matmul array. Each stream presents packed IEEE-style floats with valid/ready handshakes. A requester may lock the stage for a multi-element burst, such as one matrix row. The granted element is split into sign, widened exponent and fixed-point mantissa, then registered toward the multiplier with its requester ID.

---
 rtl/float_pkg.sv | 37 +++
 rtl/float_break.sv | 29 ++
 rtl/float_unpack_arbiter.sv | 127 ++++++++++++
 tb/tb_float_unpack_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and helpers for the float unpack arbiter and its unpack stage.
// Holds the width helpers, the arbiter state enum and the round-robin pick function.
package float_pkg;

    localparam int RR_MAX = 32;

    function automatic int float_width(input int exp_w, input int man_w);
        return exp_w + man_w + 1;
    endfunction

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Nearest valid requester after ptr (wrapping); -1 when nothing is valid.
    // Scanning from the farthest position lets the nearest hit overwrite the rest.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
        int idx;
        int pick;
        pick = -1;
        for (int k = RR_MAX; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (valid[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/float_break.sv
// Splits a packed float into sign, widened exponent and fixed-point mantissa.
// Purely combinational, no backpressure; subnormals take exponent 1 with no hidden bit.
module float_break
    import float_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic [float_width(EXP_WIDTH, MAN_WIDTH)-1:0] word,
    output logic                                         sign,
    output logic [EXP_WIDTH+1:0]                         exp,
    output logic [MAN_WIDTH+2:0]                         man
);

    localparam int FW = float_width(EXP_WIDTH, MAN_WIDTH);

    logic [EXP_WIDTH-1:0] exp_field;
    logic [MAN_WIDTH-1:0] frac;
    logic                 hidden;

    assign exp_field = word[FW-2 -: EXP_WIDTH];
    assign frac      = word[MAN_WIDTH-1:0];
    assign hidden    = |exp_field;

    assign sign = word[FW-1];
    assign exp  = hidden ? {2'b00, exp_field} : (EXP_WIDTH+2)'(1);
    assign man  = {2'b00, hidden, frac};

endmodule

// File: rtl/float_unpack_arbiter.sv
// Round-robin arbiter with burst lock feeding one shared float unpack stage.
// Latency 1 cycle accept-to-out_valid; 1 element/cycle with out_ready high.
// req_ready drops when the output register is full and out_ready is low.
module float_unpack_arbiter
    import float_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int NUM_REQ   = 4
) (
    input  logic                                                 clk,
    input  logic                                                 reset_n,
    input  logic [NUM_REQ-1:0]                                   req_valid,
    input  logic [NUM_REQ-1:0]                                   req_last,
    input  logic [NUM_REQ*float_width(EXP_WIDTH, MAN_WIDTH)-1:0] req_data,
    output logic [NUM_REQ-1:0]                                   req_ready,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic                                                 out_sign,
    output logic [EXP_WIDTH+1:0]                                 out_exp,
    output logic [MAN_WIDTH+2:0]                                 out_man,
    output logic [id_width(NUM_REQ)-1:0]                         out_id,
    output logic                                                 out_first,
    output logic                                                 out_last
);

    localparam int FW = float_width(EXP_WIDTH, MAN_WIDTH);
    localparam int IW = id_width(NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        lock_id;
    logic [IW-1:0]        grant;
    logic                 grant_valid;
    logic                 can_accept;
    logic                 accept;
    logic                 grant_last;
    logic [RR_MAX-1:0]    valid_ext;
    int                   pick;
    logic [FW-1:0]        grant_data;
    logic                 brk_sign;
    logic [EXP_WIDTH+1:0] brk_exp;
    logic [MAN_WIDTH+2:0] brk_man;

    assign can_accept = !out_valid || out_ready;
    assign valid_ext  = RR_MAX'(req_valid);
    assign pick       = rr_pick(valid_ext, int'(rr_ptr), NUM_REQ);
    assign accept     = can_accept && grant_valid;
    assign grant_last = req_last[grant];
    assign grant_data = req_data[grant*FW +: FW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= IW'(NUM_REQ - 1);
            lock_id <= '0;
        end else begin
            state <= state_nxt;
            if (accept && state == ARB_IDLE) begin
                rr_ptr <= grant;
                if (!grant_last) begin
                    lock_id <= grant;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   if (accept && !grant_last) state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (accept && grant_last)  state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    // Grant depends only on valids, state and pointer, never on data or last.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        req_ready   = '0;
        if (state == ARB_LOCKED) begin
            grant       = lock_id;
            grant_valid = req_valid[lock_id];
        end else if (pick >= 0) begin
            grant       = IW'(pick);
            grant_valid = 1'b1;
        end
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    float_break #(
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH)
    ) u_break (
        .word (grant_data),
        .sign (brk_sign),
        .exp  (brk_exp),
        .man  (brk_man)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_man   <= '0;
            out_id    <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sign  <= brk_sign;
            out_exp   <= brk_exp;
            out_man   <= brk_man;
            out_id    <= grant;
            out_first <= (state == ARB_IDLE);
            out_last  <= grant_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_float_unpack_arbiter.sv
// Scoreboard bench for float_unpack_arbiter with hand-computed directed vectors.
// Stimulus pushes expected output records; a negedge monitor pops them on each output handshake.
module tb_float_unpack_arbiter;
    import float_pkg::*;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [9:0]   out_exp;
    logic [25:0]  out_man;
    logic [1:0]   out_id;
    logic         out_first;
    logic         out_last;

    int errors = 0;
    int checks = 0;
    logic [40:0] sb[$];

    float_unpack_arbiter #(
        .EXP_WIDTH (8),
        .MAN_WIDTH (23),
        .NUM_REQ   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_man   (out_man),
        .out_id    (out_id),
        .out_first (out_first),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] rec(input logic s, input logic [9:0] e, input logic [25:0] m,
                                        input logic [1:0] id, input logic f, input logic l);
        return {s, e, m, id, f, l};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none",
                         {out_sign, out_exp, out_man, out_id, out_first, out_last});
            end else begin
                chk("output_record", 64'({out_sign, out_exp, out_man, out_id, out_first, out_last}),
                    64'(sb.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [31:0] d);
        req_valid[i]       = v;
        req_last[i]        = l;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic wait_accept(input int i, input string name);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                step();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: got no accept expected accept within 50 cycles", name);
    endtask

    task automatic drain(input string name);
        repeat (5) step();
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    logic [31:0] bd[3];
    logic [40:0] be[3];

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_fields", 64'({out_sign, out_exp, out_man, out_id, out_first, out_last}), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(ARB_IDLE));
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("idle_ready", 64'(req_ready), 64'd0);

        // Single requester, unpack corner cases, all single-element bursts.
        sb.push_back(rec(1'b0, 10'h07F, 26'h0800000, 2'd0, 1'b1, 1'b1));
        set_req(0, 1'b1, 1'b1, 32'h3F800000);
        wait_accept(0, "acc_one");
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        sb.push_back(rec(1'b1, 10'h080, 26'h0800000, 2'd0, 1'b1, 1'b1));
        set_req(0, 1'b1, 1'b1, 32'hC0000000);
        wait_accept(0, "acc_neg_two");
        sb.push_back(rec(1'b0, 10'h001, 26'h0000001, 2'd0, 1'b1, 1'b1));
        set_req(0, 1'b1, 1'b1, 32'h00000001);
        wait_accept(0, "acc_subnormal");
        sb.push_back(rec(1'b0, 10'h001, 26'h0000000, 2'd0, 1'b1, 1'b1));
        set_req(0, 1'b1, 1'b1, 32'h00000000);
        wait_accept(0, "acc_zero");
        set_req(0, 1'b0, 1'b0, 32'h0);
        drain("drain_unpack");

        // Round robin from reset with all four requesters always valid.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 32'h3F800000 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            sb.push_back(rec(1'b0, 10'h07F, 26'h0800000 | 26'(k % 4), 2'(k % 4), 1'b1, 1'b1));
            @(negedge clk);
            chk("rr_ready_onehot", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            step();
        end
        req_valid = '0;
        drain("drain_rr");

        // Locked burst from requester 2 (pointer now at 1) while 0 and 1 wait.
        bd[0] = 32'h40400000; be[0] = rec(1'b0, 10'h080, 26'h0C00000, 2'd2, 1'b1, 1'b0);
        bd[1] = 32'h3F000000; be[1] = rec(1'b0, 10'h07E, 26'h0800000, 2'd2, 1'b0, 1'b0);
        bd[2] = 32'h80000000; be[2] = rec(1'b1, 10'h001, 26'h0000000, 2'd2, 1'b0, 1'b1);
        set_req(0, 1'b1, 1'b1, 32'h3F800000);
        set_req(1, 1'b1, 1'b1, 32'h40000000);
        for (int k = 0; k < 3; k++) begin
            set_req(2, 1'b1, (k == 2), bd[k]);
            sb.push_back(be[k]);
            @(negedge clk);
            chk("burst_ready", 64'(req_ready), 64'(4'b0100));
            step();
        end
        set_req(2, 1'b0, 1'b0, 32'h0);
        sb.push_back(rec(1'b0, 10'h07F, 26'h0800000, 2'd0, 1'b1, 1'b1));
        @(negedge clk);
        chk("after_burst_ready", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid = '0;
        drain("drain_burst");

        // Backpressure: held element stays stable, next element waits, then flows with no bubble.
        out_ready = 1'b0;
        sb.push_back(rec(1'b0, 10'h082, 26'h0A00000, 2'd3, 1'b1, 1'b1));
        sb.push_back(rec(1'b0, 10'h001, 26'h0400000, 2'd3, 1'b1, 1'b1));
        set_req(3, 1'b1, 1'b1, 32'h41200000);
        wait_accept(3, "acc_bp_first");
        set_req(3, 1'b1, 1'b1, 32'h00400000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_hold", 64'({out_valid, out_exp, out_man, out_id}),
                64'({1'b1, 10'h082, 26'h0A00000, 2'd3}));
            step();
        end
        out_ready = 1'b1;
        wait_accept(3, "acc_bp_second");
        chk("bp_no_bubble", 64'({out_valid, out_man}), 64'({1'b1, 26'h0400000}));
        set_req(3, 1'b0, 1'b0, 32'h0);
        drain("drain_bp");

        // Asynchronous reset in the middle of a locked burst.
        out_ready = 1'b0;
        set_req(3, 1'b1, 1'b0, 32'h3F800000);
        wait_accept(3, "acc_pre_reset");
        set_req(3, 1'b0, 1'b0, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'hBF800000);
        chk("pre_reset_locked", 64'({out_valid, dut.state}), 64'({1'b1, ARB_LOCKED}));
        chk("locked_blocks_other", 64'(req_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("reset_drops_valid", 64'(out_valid), 64'd0);
        chk("reset_state_idle", 64'(dut.state), 64'(ARB_IDLE));
        out_ready = 1'b1;
        sb.push_back(rec(1'b1, 10'h07F, 26'h0800000, 2'd1, 1'b1, 1'b1));
        #2;
        reset_n = 1'b1;
        wait_accept(1, "acc_post_reset");
        set_req(1, 1'b0, 1'b0, 32'h0);
        drain("drain_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
